// File: rtl/pipe_fwd_mux.sv
// pipe_fwd_mux: operand bypass for the ID stage.
// A short shift register follows every instruction issued from ID. Each
// source operand takes the data of its youngest in-flight producer, or the
// register-file value when no producer matches. A load-use stall is raised
// when that youngest producer is a load whose data is not yet available.
module pipe_fwd_mux #(
  parameter int WIDTH      = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  localparam int SRC_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic                   id_wen,
  input  logic [AW-1:0]          id_waddr,
  input  logic                   id_is_load,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [AW-1:0]          rs_addr,
  input  logic [AW-1:0]          rt_addr,
  input  logic [WIDTH-1:0]       rs_rf,
  input  logic [WIDTH-1:0]       rt_rf,
  input  logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [WIDTH-1:0]       rs_out,
  output logic [WIDTH-1:0]       rt_out,
  output logic [SRC_W-1:0]       rs_src,
  output logic [SRC_W-1:0]       rt_src,
  output logic                   hazard_stall
);

  // One tracked instruction; entry 0 sits in EXE, entry DEPTH-1 is oldest.
  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] waddr;
    logic          is_load;
  } trk_entry_t;

  trk_entry_t trk [DEPTH];

  logic rs_haz;
  logic rt_haz;
  logic issue_valid;

  // Youngest-producer selection for both operands.
  // NOTE: blocking assignments in always_comb, every output defaulted first
  // so no path leaves a signal unassigned (no latch); the loop walks from
  // oldest to youngest so the youngest match is the last one written.
  always_comb begin
    rs_out = rs_rf;
    rs_src = '0;
    rs_haz = 1'b0;
    rt_out = rt_rf;
    rt_src = '0;
    rt_haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (trk[k].valid && trk[k].wen) begin
        if ((rs_addr != '0) && (trk[k].waddr == rs_addr)) begin
          rs_out = stage_data[k*WIDTH +: WIDTH];
          rs_src = SRC_W'(k + 1);
          rs_haz = trk[k].is_load && (k < LOAD_READY);
        end
        if ((rt_addr != '0) && (trk[k].waddr == rt_addr)) begin
          rt_out = stage_data[k*WIDTH +: WIDTH];
          rt_src = SRC_W'(k + 1);
          rt_haz = trk[k].is_load && (k < LOAD_READY);
        end
      end
    end
  end

  assign hazard_stall = id_valid && ((id_use_rs && rs_haz) || (id_use_rt && rt_haz));

  // A killed or stalled ID instruction enters EXE as a bubble.
  assign issue_valid = id_valid && !flush && !hazard_stall;

  // Tracker shift: reset clears valid bits, freeze holds, otherwise advance.
  // NOTE: only the valid bits are reset; the payload fields are meaningless
  // while valid is low, so they carry no reset and stay plain flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        trk[k].valid <= 1'b0;
      end
    end else if (!freeze) begin
      trk[0] <= '{valid: issue_valid, wen: id_wen, waddr: id_waddr, is_load: id_is_load};
      for (int k = 1; k < DEPTH; k++) begin
        trk[k] <= trk[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_fwd_mux.sv
// Bench for pipe_fwd_mux: directed scenarios followed by a random run, all
// checked against a log-of-issued-instructions reference model.
module tb_pipe_fwd_mux;

  localparam int WIDTH      = 32;
  localparam int AW         = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 2;
  localparam int SRC_W      = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   freeze;
  logic                   flush;
  logic                   id_valid;
  logic                   id_wen;
  logic [AW-1:0]          id_waddr;
  logic                   id_is_load;
  logic                   id_use_rs;
  logic                   id_use_rt;
  logic [AW-1:0]          rs_addr;
  logic [AW-1:0]          rt_addr;
  logic [WIDTH-1:0]       rs_rf;
  logic [WIDTH-1:0]       rt_rf;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [WIDTH-1:0]       rs_out;
  logic [WIDTH-1:0]       rt_out;
  logic [SRC_W-1:0]       rs_src;
  logic [SRC_W-1:0]       rt_src;
  logic                   hazard_stall;

  int checks   = 0;
  int failures = 0;

  pipe_fwd_mux #(
    .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wen(id_wen), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_rf(rs_rf), .rt_rf(rt_rf),
    .stage_data(stage_data), .rs_out(rs_out), .rt_out(rt_out),
    .rs_src(rs_src), .rt_src(rt_src), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Reference model: a log of issued instructions stamped with the advance
  // count at issue. Its pipeline position is derived from elapsed advances.
  typedef struct {
    logic [AW-1:0] waddr;
    bit            wen;
    bit            is_load;
    int            born;
  } rec_t;

  rec_t log_q[$];
  int   tick = 0;

  function automatic int rec_stage(input rec_t r);
    return tick - r.born - 1;
  endfunction

  function automatic void ref_operand(input logic [AW-1:0] a, input logic [WIDTH-1:0] rf,
                                      output logic [WIDTH-1:0] out, output int src,
                                      output bit haz);
    int best = DEPTH;
    bit best_load = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].wen && a != 0 && log_q[i].waddr == a && rec_stage(log_q[i]) < best) begin
        best      = rec_stage(log_q[i]);
        best_load = log_q[i].is_load;
      end
    end
    if (best < DEPTH) begin
      out = stage_data[best*WIDTH +: WIDTH];
      src = best + 1;
      haz = best_load && (best < LOAD_READY);
    end else begin
      out = rf;
      src = 0;
      haz = 1'b0;
    end
  endfunction

  function automatic bit ref_stall();
    logic [WIDTH-1:0] o;
    int s;
    bit hrs, hrt;
    ref_operand(rs_addr, rs_rf, o, s, hrs);
    ref_operand(rt_addr, rt_rf, o, s, hrt);
    return id_valid && ((id_use_rs && hrs) || (id_use_rt && hrt));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every forwarding output against the model (at the negedge).
  task automatic check_all(input string tag);
    logic [WIDTH-1:0] o_rs, o_rt;
    int s_rs, s_rt;
    bit h_rs, h_rt;
    @(negedge clk);
    ref_operand(rs_addr, rs_rf, o_rs, s_rs, h_rs);
    ref_operand(rt_addr, rt_rf, o_rt, s_rt, h_rt);
    chk({tag, ".rs_out"}, 64'(rs_out), 64'(o_rs));
    chk({tag, ".rs_src"}, 64'(rs_src), 64'(s_rs));
    chk({tag, ".rt_out"}, 64'(rt_out), 64'(o_rt));
    chk({tag, ".rt_src"}, 64'(rt_src), 64'(s_rt));
    chk({tag, ".stall"}, 64'(hazard_stall), 64'(ref_stall()));
  endtask

  // Clock edge: apply the pipeline rules to the model, then release inputs.
  task automatic advance();
    bit stall_now;
    stall_now = ref_stall();
    @(posedge clk);
    if (rst) begin
      log_q.delete();
    end else if (!freeze) begin
      if (id_valid && !flush && !stall_now)
        log_q.push_back('{waddr: id_waddr, wen: id_wen, is_load: id_is_load, born: tick});
      tick++;
      for (int i = log_q.size() - 1; i >= 0; i--)
        if (rec_stage(log_q[i]) >= DEPTH) log_q.delete(i);
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_wen = 1'b0; id_waddr = '0; id_is_load = 1'b0;
    id_use_rs = 1'b0; id_use_rt = 1'b0;
  endtask

  task automatic issue(input logic wen, input logic [AW-1:0] waddr, input logic ld);
    id_valid = 1'b1; id_wen = wen; id_waddr = waddr; id_is_load = ld;
  endtask

  initial begin
    idle();
    rs_addr = '0; rt_addr = '0; rs_rf = '0; rt_rf = '0; stage_data = '0;
    rst = 1'b1;
    advance();
    rst = 1'b0;

    // Reset state: register-file values pass through.
    rs_addr = 5'd3; rs_rf = 32'h11; rt_addr = 5'd4; rt_rf = 32'h22;
    check_all("reset");
    chk("reset.rs_out_const", 64'(rs_out), 64'h11);
    chk("reset.stall_const", 64'(hazard_stall), 64'h0);
    advance();

    // ALU write of r5, then readers in EXE and MEM distance.
    issue(1'b1, 5'd5, 1'b0);
    check_all("alu_issue");
    advance();
    idle(); id_valid = 1'b1; rs_addr = 5'd5; id_use_rs = 1'b1;
    stage_data = {32'h3333, 32'h2222, 32'hAAAA};
    check_all("fwd_exe");
    chk("fwd_exe.rs_out_const", 64'(rs_out), 64'hAAAA);
    chk("fwd_exe.rs_src_const", 64'(rs_src), 64'd1);
    advance();
    check_all("fwd_mem");
    chk("fwd_mem.rs_src_const", 64'(rs_src), 64'd2);
    advance();

    // Two r5 producers (stages 2 and 0) plus an r0 writer in stage 1.
    idle(); issue(1'b1, 5'd5, 1'b0); advance();
    idle(); issue(1'b1, 5'd0, 1'b0); advance();
    idle(); issue(1'b1, 5'd5, 1'b0); advance();
    idle(); id_valid = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
    rs_addr = 5'd5; rt_addr = 5'd0; rt_rf = 32'h55;
    stage_data = {32'h2, 32'h1, 32'h0};
    check_all("youngest");
    chk("youngest.rs_out_const", 64'(rs_out), 64'h0);
    chk("r0.rt_out_const", 64'(rt_out), 64'h55);
    chk("r0.rt_src_const", 64'(rt_src), 64'd0);
    advance();

    // Load r7, immediate user of rt: two stall cycles, then WB forward.
    idle(); rs_addr = '0; rt_addr = '0; advance(); advance(); advance();
    issue(1'b1, 5'd7, 1'b1); advance();
    idle(); id_valid = 1'b1; rt_addr = 5'd7; id_use_rt = 1'b1;
    stage_data = {32'hD00D, 32'hB0B0, 32'hC0C0};
    for (int i = 0; i < 2; i++) begin
      check_all($sformatf("ldu_stall%0d", i));
      chk($sformatf("ldu_stall%0d.const", i), 64'(hazard_stall), 64'd1);
      advance();
    end
    check_all("ldu_release");
    chk("ldu_release.src_const", 64'(rt_src), 64'd3);
    chk("ldu_release.out_const", 64'(rt_out), 64'hD00D);
    advance();

    // Same sequence without the operand being read: no stall.
    idle(); issue(1'b1, 5'd7, 1'b1); advance();
    idle(); id_valid = 1'b1; rt_addr = 5'd7; id_use_rt = 1'b0;
    check_all("ldu_unused");
    chk("ldu_unused.const", 64'(hazard_stall), 64'd0);
    advance();

    // Freeze for three cycles with the load in EXE.
    idle(); rt_addr = '0; issue(1'b1, 5'd9, 1'b1); advance();
    idle(); id_valid = 1'b1; rs_addr = 5'd9; id_use_rs = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("freeze%0d", i));
      chk($sformatf("freeze%0d.src_const", i), 64'(rs_src), 64'd1);
      advance();
    end
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("unfreeze%0d", i));
      advance();
    end

    // Flushed write leaves a bubble: no forward for the following reader.
    idle(); rs_addr = '0; advance(); advance(); advance();
    issue(1'b1, 5'd12, 1'b0); flush = 1'b1; advance();
    idle(); id_valid = 1'b1; rs_addr = 5'd12; id_use_rs = 1'b1;
    check_all("flush");
    chk("flush.src_const", 64'(rs_src), 64'd0);
    advance();

    // Reset in the middle of a load-use stall.
    idle(); issue(1'b1, 5'd3, 1'b1); advance();
    idle(); id_valid = 1'b1; rs_addr = 5'd3; id_use_rs = 1'b1;
    check_all("pre_rst_stall");
    rst = 1'b1; advance(); rst = 1'b0;
    check_all("post_rst");
    chk("post_rst.stall_const", 64'(hazard_stall), 64'd0);
    chk("post_rst.src_const", 64'(rs_src), 64'd0);
    advance();

    // Random traffic over a small register range to force frequent matches.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      freeze     = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      id_valid   = ($urandom_range(0, 4) != 0);
      id_wen     = ($urandom_range(0, 3) != 0);
      id_waddr   = AW'($urandom_range(0, 7));
      id_is_load = ($urandom_range(0, 2) == 0);
      id_use_rs  = $urandom_range(0, 1) == 1;
      id_use_rt  = $urandom_range(0, 1) == 1;
      rs_addr    = AW'($urandom_range(0, 7));
      rt_addr    = AW'($urandom_range(0, 7));
      rs_rf      = $urandom;
      rt_rf      = $urandom;
      for (int k = 0; k < DEPTH; k++) stage_data[k*WIDTH +: WIDTH] = $urandom;
      check_all($sformatf("rand%0d", n));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
